// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and constants for the ALU result BCD converter
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } bcd_state_t;

    localparam logic [3:0] BCD_ERR_NIBBLE = 4'hF;

    // Smallest digit count d with 10^d > 2^(2*w).
    function automatic int digits_for(input int w);
        longint lim;
        longint p;
        int     d;
        lim = longint'(1) << (2 * w);
        p   = 1;
        d   = 0;
        for (int i = 0; i < 20; i++) begin
            if (p <= lim) begin
                p = p * 10;
                d = d + 1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - double-dabble add-3 adjust for one BCD nibble
module bcd_digit_adj (
    input  logic [3:0] i_nibble,
    output logic [3:0] o_nibble
);

    assign o_nibble = (i_nibble >= 4'd5) ? i_nibble + 4'd3 : i_nibble;

endmodule

// File: rtl/alu_result_bcd.sv
// rtl/alu_result_bcd.sv - sequential binary-to-BCD converter for ALU results
module alu_result_bcd
    import alu_pkg::*;
#(
    parameter int width  = 6,
    parameter int digits = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*width-1:0]    bin,
    input  logic                  ovf_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*digits-1:0]   bcd,
    output logic                  ovf_out,
    output logic                  busy
);

    localparam int BW = 2 * width;
    localparam int AW = 4 * digits;
    localparam int CW = $clog2(2 * width + 1);

    if (digits < digits_for(width)) begin : g_digits_check
        $error("alu_result_bcd: digits too small for 2*width-bit result");
    end

    bcd_state_t     r_state;
    bcd_state_t     w_next;
    logic [BW-1:0]  r_shift;
    logic [AW-1:0]  r_acc;
    logic [AW-1:0]  r_bcd;
    logic [CW-1:0]  r_cnt;
    logic           r_ovf;
    logic [AW-1:0]  w_adj;
    logic [AW-1:0]  w_acc_shift;

    for (genvar g = 0; g < digits; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_nibble (r_acc[4*g +: 4]),
            .o_nibble (w_adj[4*g +: 4])
        );
    end

    // Adjusted accumulator shifted left, taking the next binary bit from the top of r_shift.
    assign w_acc_shift = {w_adj[AW-2:0], r_shift[BW-1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = ovf_in ? DONE : CONV;
            CONV:    if (r_cnt == CW'(1)) w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE) && !rst;
        out_valid = (r_state == DONE);
        busy      = (r_state == CONV);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_acc   <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_shift <= bin;
                        r_acc   <= '0;
                        r_cnt   <= CW'(BW);
                        r_ovf   <= ovf_in;
                        if (ovf_in) r_bcd <= {digits{BCD_ERR_NIBBLE}};
                    end
                end
                CONV: begin
                    r_acc   <= w_acc_shift;
                    r_shift <= r_shift << 1;
                    r_cnt   <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) r_bcd <= w_acc_shift;
                end
                default: ;
            endcase
        end
    end

    assign bcd     = r_bcd;
    assign ovf_out = r_ovf;

endmodule
